delay_line_seq: RTL and testbench
=================================

// Module: delay_line_seq
// PURPOSE
//  Sequencer for the conv/maxpool window datapath built from delayLine instances.
//  - Streams one feature-map tile as channel-words (Cin/8 words per pixel, row-major).
//  - Drives the shared delay-line enable and depth, and tracks word/col/row position.
//  - Flags each beat that completes a valid KxK window (stride 1 or 2); sits between input DMA and window/MAC stage.
// PARAMETERS
//  K        3    window size; window valid once row>=K-1 and col>=K-1
//  COL_W    10   width of column/row counters (max width/height 1023)
//  WORD_W   8    width of cin_words; equals delayLine delay_depth width
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       async active-low reset
//  cfg_start    in   1       1-cycle pulse; latches cfg_* when IDLE, ignored otherwise
//  cfg_width    in   COL_W   pixels per row
//  cfg_height   in   COL_W   rows
//  cfg_cin_words in  WORD_W  channel-words per pixel (Cin/8), >=1
//  cfg_stride2  in   1       1: stride 2, 0: stride 1
//  s_valid      in   1       input beat valid
//  s_ready      out  1       input beat accepted when s_valid&&s_ready
//  m_ready      in   1       downstream window stage can take a beat
//  dl_en        out  1       enable to all delay lines (= accepted beat, comb)
//  dl_depth     out  WORD_W  delay_depth to all delay lines (latched cin_words)
//  dl_rst       out  1       1-cycle sync clear to delay lines on tile start
//  win_valid    out  1       registered; beat leaving delay lines completes a window
//  win_last     out  1       registered; last word of last window of tile
//  busy         out  1       state != IDLE
//  done         out  1       1-cycle pulse at tile end
//  cfg_err      out  1       sticky until next cfg_start; bad config rejected
// BEHAVIOUR
//  Reset: state=IDLE, all counters 0; dl_depth=0; s_ready, dl_en, dl_rst, win_valid, win_last, done, busy, cfg_err =0.
//  States: IDLE -> CLEAR -> RUN -> DRAIN -> IDLE.
//   IDLE: on cfg_start check config.
//    cin_words==0, width<K or height<K -> cfg_err=1, stay IDLE.
//    Otherwise latch config, cfg_err=0, go CLEAR.
//   CLEAR: exactly 1 cycle; dl_rst=1, s_ready=0; go RUN.
//   RUN: s_ready = m_ready (comb). dl_en = s_valid&&s_ready.
//   Counters advance only on accepted beats:
//    word 0..cin_words-1 wraps -> col++; col 0..width-1 wraps -> row++.
//   Window tag for the accepted beat = (row>=K-1)&&(col>=K-1);
//    with stride2 additionally (row-(K-1))[0]==0 && (col-(K-1))[0]==0.
//   Delay-line latency is 1 cycle: win_valid registered 1 cycle after the beat,
//    aligned with delayLine dout; win_valid=0 on non-accepted cycles.
//   Accept of word==cin_words-1, col==width-1, row==height-1 -> DRAIN; win_last set with that win_valid.
//   DRAIN: 1 cycle, s_ready=0, output tags flush; done=1 during DRAIN cycle; go IDLE.
//  Backpressure: m_ready=0 -> s_ready=0, dl_en=0; delay lines and counters hold, no beat lost.
//  Simultaneous: cfg_start during CLEAR/RUN/DRAIN ignored; s_valid in IDLE/CLEAR not accepted.
//  cin_words==1: delay lines bypass internally; sequencing unchanged (word counter always 0).
//  Async reset mid-tile: immediate return to IDLE, outputs to reset values; next tile needs cfg_start.
//  Width rules: counters compare against latched cfg-1 (computed at latch, no underflow since >=K>=1).
// STRUCTURE
//  Shared pkg yolo_pkg: typedef enum logic[1:0] {SEQ_IDLE,SEQ_CLEAR,SEQ_RUN,SEQ_DRAIN} seq_state_t;
//   localparams COL_W, WORD_W shared with delayLine instantiations.
//  Sub-module: pos_counter (cascaded word/col/row counter with wrap and last flags).
//  Delay lines and window registers stay outside; this block only drives en/depth/rst and tags.
// TESTING
//  1 width=4,height=4,cin=1,stride1, s_valid=1,m_ready=1 -> 16 beats, win_valid on beats 11,12,15,16 (1-idx, +1 cyc), win_last with beat 16, done once.
//  2 width=5,height=5,cin=2,stride2 -> windows at (r,c)=(2,2),(2,4),(4,2),(4,4); win_valid high 2 words each = 8 cycles total.
//  3 cfg cin=0 or width=2 -> cfg_err=1, busy=0, s_ready=0; next valid cfg_start clears cfg_err.
//  4 case1 with m_ready toggling 1010.. -> dl_en only when m_ready=1, identical win_valid sequence per accepted beat.
//  5 rst_n low at beat 7 of case1 -> all outputs 0 same cycle; restart gives full case1 result.
//  6 cfg_start pulsed in RUN with different width -> ignored; tile completes with original width; dl_rst exactly 1 cycle per tile.

Source files
------------

// File: rtl/delay_line_seq_pkg.sv
// delay_line_seq_pkg: shared sequencer states, sizes and window-tag helper
package delay_line_seq_pkg;
  localparam int K = 3;
  localparam int COL_W = 10;
  localparam int WORD_W = 8;
  localparam logic [COL_W-1:0] KM1 = COL_W'(K - 1);
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_CLEAR, SEQ_RUN, SEQ_DRAIN} seq_state_t;
  // stride 2 keeps only windows whose top-left offset from K-1 is even in both axes
  function automatic logic win_tag(input logic [COL_W-1:0] row, input logic [COL_W-1:0] col,
                                   input logic stride2);
    return row >= KM1 && col >= KM1 && (!stride2 || (row[0] == KM1[0] && col[0] == KM1[0]));
  endfunction
endpackage

// File: rtl/delay_line_seq_if.sv
// delay_line_seq_if: input stream handshake and delay-line control/tag bundle
interface delay_line_seq_if;
  import delay_line_seq_pkg::*;
  logic s_valid;
  logic s_ready;
  logic m_ready;
  logic dl_en;
  logic [WORD_W-1:0] dl_depth;
  logic dl_rst;
  logic win_valid;
  logic win_last;
  modport master (output s_valid, m_ready,
                  input s_ready, dl_en, dl_depth, dl_rst, win_valid, win_last);
  modport slave (input s_valid, m_ready,
                 output s_ready, dl_en, dl_depth, dl_rst, win_valid, win_last);
endinterface

// File: rtl/delay_line_seq_pos_counter.sv
// delay_line_seq_pos_counter: cascaded word/col/row position counter with wrap flags
module delay_line_seq_pos_counter
  import delay_line_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic [WORD_W-1:0] word_max,
  input  logic [COL_W-1:0]  col_max,
  input  logic [COL_W-1:0]  row_max,
  output logic [COL_W-1:0]  col,
  output logic [COL_W-1:0]  row,
  output logic             word_last,
  output logic             col_last,
  output logic             row_last
);
  logic [WORD_W-1:0] word;
  assign word_last = word == word_max;
  assign col_last = col == col_max;
  assign row_last = row == row_max;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      word <= '0;
      col <= '0;
      row <= '0;
    end else if (clr) begin
      word <= '0;
      col <= '0;
      row <= '0;
    end else if (adv) begin
      word <= word_last ? '0 : word + 1'b1;
      if (word_last) col <= col_last ? '0 : col + 1'b1;
      if (word_last && col_last) row <= row_last ? '0 : row + 1'b1;
    end
endmodule

// File: rtl/delay_line_seq.sv
// delay_line_seq: tile sequencer driving shared delay-line enable/depth/clear
// and tagging beats that complete a KxK window (stride 1 or 2).
module delay_line_seq
  import delay_line_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [COL_W-1:0]  cfg_width,
  input  logic [COL_W-1:0]  cfg_height,
  input  logic [WORD_W-1:0] cfg_cin_words,
  input  logic              cfg_stride2,
  delay_line_seq_if.slave   io,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);
  seq_state_t state, state_nxt;
  logic [WORD_W-1:0] depth, word_max;
  logic [COL_W-1:0] col_max, row_max, col, row;
  logic stride2, word_last, col_last, row_last;
  logic accept, tile_last, bad_cfg, tag, rst_q, wv, wl;
  assign bad_cfg = cfg_cin_words == '0 || cfg_width < COL_W'(K) || cfg_height < COL_W'(K);
  assign io.s_ready = state == SEQ_RUN && io.m_ready;
  assign accept = io.s_ready && io.s_valid;
  assign io.dl_en = accept;
  assign io.dl_depth = depth;
  assign io.dl_rst = rst_q;
  assign io.win_valid = wv;
  assign io.win_last = wl;
  assign tile_last = word_last && col_last && row_last;
  assign tag = win_tag(row, col, stride2);
  always_comb
    state_nxt = state == SEQ_IDLE  ? (cfg_start && !bad_cfg ? SEQ_CLEAR : SEQ_IDLE) :
                state == SEQ_CLEAR ? SEQ_RUN :
                state == SEQ_RUN   ? (accept && tile_last ? SEQ_DRAIN : SEQ_RUN) :
                                     SEQ_IDLE;
  // wrap limits are stored as cfg-1 so the counters compare directly
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= SEQ_IDLE;
      depth <= '0;
      word_max <= '0;
      col_max <= '0;
      row_max <= '0;
      stride2 <= 1'b0;
      cfg_err <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      rst_q <= 1'b0;
      wv <= 1'b0;
      wl <= 1'b0;
    end else begin
      state <= state_nxt;
      busy <= state_nxt != SEQ_IDLE;
      done <= state_nxt == SEQ_DRAIN;
      rst_q <= state_nxt == SEQ_CLEAR;
      wv <= accept && tag;
      wl <= accept && tag && tile_last;
      if (state == SEQ_IDLE && cfg_start) begin
        cfg_err <= bad_cfg;
        if (!bad_cfg) begin
          depth <= cfg_cin_words;
          word_max <= cfg_cin_words - 1'b1;
          col_max <= cfg_width - 1'b1;
          row_max <= cfg_height - 1'b1;
          stride2 <= cfg_stride2;
        end
      end
    end
  delay_line_seq_pos_counter u_pos (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state == SEQ_CLEAR),
    .adv(accept),
    .word_max(word_max),
    .col_max(col_max),
    .row_max(row_max),
    .col(col),
    .row(row),
    .word_last(word_last),
    .col_last(col_last),
    .row_last(row_last)
  );
endmodule

// File: tb/tb_delay_line_seq.sv
// tb_delay_line_seq: directed tiles with hand-computed window masks
module tb_delay_line_seq;
  import delay_line_seq_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_start = 1'b0;
  logic cfg_stride2 = 1'b0;
  logic [COL_W-1:0] cfg_width = '0;
  logic [COL_W-1:0] cfg_height = '0;
  logic [WORD_W-1:0] cfg_cin_words = '0;
  logic busy, done, cfg_err;
  int total = 0;
  int bad = 0;
  logic [63:0] mask;
  int nacc, nwin, nlast, last_idx, ndone, nrst, nbad;
  bit fin;
  delay_line_seq_if io ();
  delay_line_seq dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_width(cfg_width),
    .cfg_height(cfg_height), .cfg_cin_words(cfg_cin_words), .cfg_stride2(cfg_stride2),
    .io(io), .busy(busy), .done(done), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_tile(input int w, input int h, input int cin, input logic s2,
                          input bit toggle, input int glitch_at, input int rst_at);
    int prev = 0;
    mask = '0; nacc = 0; nwin = 0; nlast = 0; last_idx = 0; ndone = 0; nrst = 0; nbad = 0; fin = 0;
    @(negedge clk);
    cfg_width = COL_W'(w); cfg_height = COL_W'(h); cfg_cin_words = WORD_W'(cin);
    cfg_stride2 = s2; cfg_start = 1'b1; io.s_valid = 1'b1; io.m_ready = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      io.m_ready = !toggle || (c % 2 == 0);
      cfg_start = c == glitch_at;
      cfg_width = COL_W'(c == glitch_at ? 5 : w);
      #1;
      nrst += int'(io.dl_rst);
      if (io.win_valid) begin
        nwin++;
        if (prev > 0) mask[prev-1] = 1'b1; else nbad++;
      end
      if (io.win_last) begin nlast++; last_idx = prev; end
      if (io.dl_en && !io.m_ready) nbad++;
      ndone += int'(done);
      if (done) fin = 1;
      prev = io.dl_en ? nacc + 1 : 0;
      nacc += int'(io.dl_en);
      if (rst_at > 0 && nacc == rst_at && io.dl_en) begin
        rst_n = 1'b0;
        #1;
        return;
      end
      if (!fin) @(negedge clk);
    end
    cfg_start = 1'b0;
    cfg_width = COL_W'(w);
  endtask
  initial begin
    io.s_valid = 1'b0;
    io.m_ready = 1'b0;
    #12;
    check("rst s_ready", int'(io.s_ready), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst cfg_err", int'(cfg_err), 0);
    check("rst dl_depth", int'(io.dl_depth), 0);
    check("rst win_valid", int'(io.win_valid), 0);
    check("rst dl_rst", int'(io.dl_rst), 0);
    @(negedge clk) rst_n = 1'b1;
    // 4x4, one word per pixel, stride 1: windows on beats 11,12,15,16
    run_tile(4, 4, 1, 1'b0, 1'b0, -1, 0);
    check("c1 fin", int'(fin), 1);
    check("c1 beats", nacc, 16);
    check("c1 mask", int'(mask[31:0]), 32'h0000_CC00);
    check("c1 nwin", nwin, 4);
    check("c1 nlast", nlast, 1);
    check("c1 last_idx", last_idx, 16);
    check("c1 ndone", ndone, 1);
    check("c1 dl_rst", nrst, 1);
    check("c1 bad", nbad, 0);
    check("c1 depth", int'(io.dl_depth), 1);
    @(negedge clk); #1;
    check("c1 idle busy", int'(busy), 0);
    check("c1 idle done", int'(done), 0);
    // 5x5, two words per pixel, stride 2: pixels (2,2),(2,4),(4,2),(4,4)
    run_tile(5, 5, 2, 1'b1, 1'b0, -1, 0);
    check("c2 fin", int'(fin), 1);
    check("c2 beats", nacc, 50);
    check("c2 mask lo", int'(mask[31:0]), 32'h3300_0000);
    check("c2 mask hi", int'(mask[63:32]), 32'h0003_3000);
    check("c2 nwin", nwin, 8);
    check("c2 last_idx", last_idx, 50);
    check("c2 ndone", ndone, 1);
    check("c2 depth", int'(io.dl_depth), 2);
    check("c2 bad", nbad, 0);
    @(negedge clk);
    cfg_width = 10'd4; cfg_height = 10'd4; cfg_cin_words = 8'd0; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    #1;
    check("c3 cin0 err", int'(cfg_err), 1);
    check("c3 cin0 busy", int'(busy), 0);
    check("c3 cin0 s_ready", int'(io.s_ready), 0);
    check("c3 cin0 dl_en", int'(io.dl_en), 0);
    @(negedge clk);
    cfg_width = 10'd2; cfg_cin_words = 8'd1; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    #1;
    check("c3 w2 err", int'(cfg_err), 1);
    check("c3 w2 busy", int'(busy), 0);
    run_tile(4, 4, 1, 1'b0, 1'b0, -1, 0);
    check("c3 err cleared", int'(cfg_err), 0);
    check("c3 mask", int'(mask[31:0]), 32'h0000_CC00);
    // backpressure alternating every cycle
    run_tile(4, 4, 1, 1'b0, 1'b1, -1, 0);
    check("c4 fin", int'(fin), 1);
    check("c4 beats", nacc, 16);
    check("c4 mask", int'(mask[31:0]), 32'h0000_CC00);
    check("c4 last_idx", last_idx, 16);
    check("c4 bad", nbad, 0);
    // async reset right at beat 7
    run_tile(4, 4, 1, 1'b0, 1'b0, -1, 7);
    check("c5 beats", nacc, 7);
    check("c5 s_ready", int'(io.s_ready), 0);
    check("c5 dl_en", int'(io.dl_en), 0);
    check("c5 busy", int'(busy), 0);
    check("c5 win_valid", int'(io.win_valid), 0);
    check("c5 dl_depth", int'(io.dl_depth), 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk); #1;
    check("c5 stays idle", int'(busy), 0);
    run_tile(4, 4, 1, 1'b0, 1'b0, -1, 0);
    check("c5 restart beats", nacc, 16);
    check("c5 restart mask", int'(mask[31:0]), 32'h0000_CC00);
    check("c5 restart last", last_idx, 16);
    // cfg_start with width 5 mid-run must be ignored
    run_tile(4, 4, 1, 1'b0, 1'b0, 5, 0);
    check("c6 fin", int'(fin), 1);
    check("c6 beats", nacc, 16);
    check("c6 mask", int'(mask[31:0]), 32'h0000_CC00);
    check("c6 dl_rst", nrst, 1);
    check("c6 last_idx", last_idx, 16);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
